// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD engine: controller states and
// the encoding of the algorithm-select input.
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_SUB = 1'b0;
    localparam logic MODE_BIN = 1'b1;

endpackage

// File: rtl/gcd_step.sv
// One combinational GCD iteration: either a subtractive Euclid step or a
// binary (Stein) step, reporting termination and the final result.
module gcd_step
    import gcd_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int KW    = 4
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [KW-1:0]    i_k,
    input  logic             i_mode,
    output logic [WIDTH-1:0] o_a,
    output logic [WIDTH-1:0] o_b,
    output logic [KW-1:0]    o_k,
    output logic             o_term,
    output logic [WIDTH-1:0] o_result
);

    logic [WIDTH-1:0] w_diff_ab;
    logic [WIDTH-1:0] w_diff_ba;

    assign w_diff_ab = i_a - i_b;
    assign w_diff_ba = i_b - i_a;

    // Priority-ordered iteration rules; operands pass through unless a rule fires.
    always_comb begin
        o_a      = i_a;
        o_b      = i_b;
        o_k      = i_k;
        o_term   = 1'b0;
        o_result = '0;
        if (i_mode == MODE_BIN) begin
            if (i_a == '0) begin
                o_term   = 1'b1;
                o_result = i_b << i_k;
            end else if (i_b == '0) begin
                o_term   = 1'b1;
                o_result = i_a << i_k;
            end else if ((i_a[0] == 1'b0) && (i_b[0] == 1'b0)) begin
                o_a = i_a >> 1'b1;
                o_b = i_b >> 1'b1;
                o_k = i_k + KW'(1);
            end else if (i_a[0] == 1'b0) begin
                o_a = i_a >> 1'b1;
            end else if (i_b[0] == 1'b0) begin
                o_b = i_b >> 1'b1;
            end else if (i_a >= i_b) begin
                o_a = w_diff_ab >> 1'b1;
            end else begin
                o_b = w_diff_ba >> 1'b1;
            end
        end else begin
            if (i_a < i_b) begin
                o_a = i_b;
                o_b = i_a;
            end else if (i_b != '0) begin
                o_a = w_diff_ab;
            end else begin
                o_term   = 1'b1;
                o_result = i_a;
            end
        end
    end

endmodule

// File: rtl/gcd_param.sv
// Iterative GCD engine with valid/ready operand intake, a result held until
// acknowledged, and a saturating count of the iterations used.
module gcd_param
    import gcd_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    input  logic             mode_bin,
    input  logic             operands_val,
    output logic             operands_rdy,
    input  logic             ack,
    output logic [WIDTH-1:0] gcd_out,
    output logic             gcd_valid,
    output logic [CNT_W-1:0] cycles
);

    localparam int KW = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [KW-1:0]    r_k;
    logic             r_mode;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_out;
    logic [CNT_W-1:0] r_cycles;
    logic             r_valid;
    logic             r_rdy;

    logic [WIDTH-1:0] w_a_next;
    logic [WIDTH-1:0] w_b_next;
    logic [KW-1:0]    w_k_next;
    logic             w_term;
    logic [WIDTH-1:0] w_result;
    logic [CNT_W-1:0] w_cnt_next;

    gcd_step #(
        .WIDTH (WIDTH),
        .KW    (KW)
    ) u_step (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_k      (r_k),
        .i_mode   (r_mode),
        .o_a      (w_a_next),
        .o_b      (w_b_next),
        .o_k      (w_k_next),
        .o_term   (w_term),
        .o_result (w_result)
    );

    // The terminating iteration is itself counted, so it uses the incremented value.
    assign w_cnt_next = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

    // State register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (operands_val) begin
                    w_state_next = CALC;
                end else begin
                    w_state_next = IDLE;
                end
            end
            CALC: begin
                if (w_term) begin
                    w_state_next = DONE;
                end else begin
                    w_state_next = CALC;
                end
            end
            DONE: begin
                if (ack) begin
                    w_state_next = IDLE;
                end else begin
                    w_state_next = DONE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Operand capture, iteration registers and result latching.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_k      <= '0;
            r_mode   <= MODE_SUB;
            r_cnt    <= '0;
            r_out    <= '0;
            r_cycles <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (operands_val) begin
                        r_a    <= A_in;
                        r_b    <= B_in;
                        r_mode <= mode_bin;
                        r_k    <= '0;
                        r_cnt  <= '0;
                    end
                end
                CALC: begin
                    r_a   <= w_a_next;
                    r_b   <= w_b_next;
                    r_k   <= w_k_next;
                    r_cnt <= w_cnt_next;
                    if (w_term) begin
                        r_out    <= w_result;
                        r_cycles <= w_cnt_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Handshake flags follow the upcoming state so they are valid the cycle it is entered.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_rdy   <= 1'b1;
            r_valid <= 1'b0;
        end else begin
            r_rdy   <= (w_state_next == IDLE);
            r_valid <= (w_state_next == DONE);
        end
    end

    assign operands_rdy = r_rdy;
    assign gcd_valid    = r_valid;
    assign gcd_out      = r_out;
    assign cycles       = r_cycles;

endmodule

// File: tb/tb_gcd_param.sv
// Directed and randomized checks of gcd_param against an arithmetic GCD model;
// a 16-bit instance runs the long saturating case alongside the 8-bit work.
module tb_gcd_param;

    logic        clk;
    logic        rst;
    logic [7:0]  a_in;
    logic [7:0]  b_in;
    logic        mode;
    logic        val;
    logic        rdy;
    logic        ack;
    logic [7:0]  gout;
    logic        gvalid;
    logic [7:0]  gcyc;

    logic        rst16;
    logic [15:0] a16;
    logic [15:0] b16;
    logic        mode16;
    logic        val16;
    logic        rdy16;
    logic        ack16;
    logic [15:0] gout16;
    logic        gvalid16;
    logic [7:0]  gcyc16;

    int n_cmp;
    int n_fail;

    gcd_param #(.WIDTH(8), .CNT_W(8)) dut (
        .Clk(clk), .Rst(rst), .A_in(a_in), .B_in(b_in), .mode_bin(mode),
        .operands_val(val), .operands_rdy(rdy), .ack(ack),
        .gcd_out(gout), .gcd_valid(gvalid), .cycles(gcyc)
    );

    gcd_param #(.WIDTH(16), .CNT_W(8)) dut16 (
        .Clk(clk), .Rst(rst16), .A_in(a16), .B_in(b16), .mode_bin(mode16),
        .operands_val(val16), .operands_rdy(rdy16), .ack(ack16),
        .gcd_out(gout16), .gcd_valid(gvalid16), .cycles(gcyc16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ref_gcd(input int a, input int b);
        int x = a;
        int y = b;
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Iteration count obtained by applying the algorithm rules on plain integers.
    function automatic int ref_cycles(input int a, input int b, input bit m);
        int x = a;
        int y = b;
        int t;
        for (int n = 1; n < 100000; n++) begin
            if (!m) begin
                if (x < y) begin t = x; x = y; y = t; end
                else if (y != 0) x = x - y;
                else return n;
            end else begin
                if (x == 0 || y == 0) return n;
                else if (x % 2 == 0 && y % 2 == 0) begin x = x / 2; y = y / 2; end
                else if (x % 2 == 0) x = x / 2;
                else if (y % 2 == 0) y = y / 2;
                else if (x >= y) x = (x - y) / 2;
                else y = (y - x) / 2;
            end
        end
        return -1;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic m,
                         input int exp_g, input int exp_c, input int hold, input string tag);
        int n;
        n = 0;
        while (!rdy && n < 10) begin tick(); n++; end
        check({tag, "_rdy_idle"}, int'(rdy), 1);
        a_in = a; b_in = b; mode = m; val = 1'b1;
        tick();
        n = 0;
        // Operand and ack noise while calculating must have no effect.
        while (!gvalid && n < 400) begin
            val  = 1'($urandom);
            a_in = 8'($urandom);
            b_in = 8'($urandom);
            mode = 1'($urandom);
            ack  = 1'($urandom);
            tick();
            n++;
        end
        ack = 1'b0;
        val = 1'b0;
        check({tag, "_valid"}, int'(gvalid), 1);
        check({tag, "_gcd"}, int'(gout), exp_g);
        check({tag, "_cycles"}, int'(gcyc), (exp_c > 255) ? 255 : exp_c);
        if (exp_c < 255) check({tag, "_latency"}, n, exp_c);
        check({tag, "_rdy_done"}, int'(rdy), 0);
        for (int i = 0; i < hold; i++) begin
            val  = 1'($urandom);
            a_in = 8'($urandom);
            tick();
        end
        val = 1'b0;
        check({tag, "_hold_valid"}, int'(gvalid), 1);
        check({tag, "_hold_gcd"}, int'(gout), exp_g);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check({tag, "_ack_valid"}, int'(gvalid), 0);
        check({tag, "_ack_retain"}, int'(gout), exp_g);
        check({tag, "_ack_rdy"}, int'(rdy), 1);
    endtask

    initial begin
        int n;
        int seen;
        logic [7:0] ra;
        logic [7:0] rb;
        n_cmp = 0; n_fail = 0;
        rst = 1'b1; rst16 = 1'b1;
        a_in = '0; b_in = '0; mode = 1'b0; val = 1'b0; ack = 1'b0;
        a16 = '0; b16 = '0; mode16 = 1'b0; val16 = 1'b0; ack16 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; rst16 = 1'b0;
        check("reset_rdy", int'(rdy), 1);
        check("reset_valid", int'(gvalid), 0);
        check("reset_gcd", int'(gout), 0);
        check("reset_cycles", int'(gcyc), 0);
        check("reset16_rdy", int'(rdy16), 1);

        // Long saturating case runs on the 16-bit instance in the background.
        a16 = 16'd65535; b16 = 16'd1; mode16 = 1'b0; val16 = 1'b1;
        tick();
        val16 = 1'b0;

        do_op(8'd24, 8'd36, 1'b0, 12, 7, 10, "sub_24_36");
        do_op(8'd24, 8'd36, 1'b1, 12, 6, 2, "bin_24_36");
        do_op(8'd0, 8'd0, 1'b0, 0, 1, 1, "sub_0_0");
        do_op(8'd0, 8'd0, 1'b1, 0, 1, 1, "bin_0_0");
        do_op(8'd0, 8'd45, 1'b0, 45, 2, 1, "sub_0_45");
        do_op(8'd0, 8'd45, 1'b1, 45, 1, 1, "bin_0_45");
        do_op(8'd45, 8'd0, 1'b0, 45, 1, 1, "sub_45_0");
        do_op(8'd45, 8'd0, 1'b1, 45, 1, 1, "bin_45_0");
        do_op(8'd255, 8'd1, 1'b0, 1, 257, 1, "sub_255_1_sat");
        do_op(8'd128, 8'd192, 1'b1, 64, ref_cycles(128, 192, 1'b1), 1, "bin_128_192");

        // Abort a calculation with reset; no stale result may appear.
        a_in = 8'd100; b_in = 8'd7; mode = 1'b0; val = 1'b1;
        tick();
        val = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_valid", int'(gvalid), 0);
        check("abort_rdy", int'(rdy), 1);
        check("abort_gcd", int'(gout), 0);
        check("abort_cycles", int'(gcyc), 0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (gvalid) seen = 1;
            tick();
        end
        check("abort_no_pulse", seen, 0);
        do_op(8'd17, 8'd51, 1'b0, 17, ref_cycles(17, 51, 1'b0), 1, "post_abort_17_51");

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if ($urandom_range(0, 15) == 0) ra = 8'd0;
            if ($urandom_range(0, 15) == 0) rb = 8'd0;
            do_op(ra, rb, 1'b0, ref_gcd(int'(ra), int'(rb)), ref_cycles(int'(ra), int'(rb), 1'b0),
                  0, $sformatf("rnd%0d_sub_%0d_%0d", i, ra, rb));
            do_op(ra, rb, 1'b1, ref_gcd(int'(ra), int'(rb)), ref_cycles(int'(ra), int'(rb), 1'b1),
                  0, $sformatf("rnd%0d_bin_%0d_%0d", i, ra, rb));
        end

        n = 0;
        while (!gvalid16 && n < 70000) begin tick(); n++; end
        check("w16_sub_valid", int'(gvalid16), 1);
        check("w16_sub_gcd", int'(gout16), 1);
        check("w16_sub_cycles_sat", int'(gcyc16), 255);
        ack16 = 1'b1;
        tick();
        ack16 = 1'b0;
        check("w16_ack_valid", int'(gvalid16), 0);
        a16 = 16'd65535; b16 = 16'd1; mode16 = 1'b1; val16 = 1'b1;
        tick();
        val16 = 1'b0;
        n = 0;
        while (!gvalid16 && n < 400) begin tick(); n++; end
        check("w16_bin_valid", int'(gvalid16), 1);
        check("w16_bin_gcd", int'(gout16), 1);
        check("w16_bin_cycles", int'(gcyc16), 17);
        check("w16_bin_latency", n, 17);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
